// File: rtl/hmac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hmac_sched
//  Description : Two-requester round-robin scheduler in front of a single
//                HMAC core. Feeds key/blocks, issues init/next commands,
//                returns the tag to the owning requester, aborts on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module hmac_sched #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          zeroize,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_last,
  output logic [1:0]    req_ready,
  input  logic [767:0]  req_key,
  input  logic [2047:0] req_block,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [383:0]  rsp_tag,
  output logic          core_init,
  output logic          core_next,
  output logic          core_zeroize,
  input  logic          core_ready,
  input  logic          core_tag_valid,
  output logic [383:0]  core_key,
  output logic [1023:0] core_block,
  input  logic [383:0]  core_tag,
  output logic          busy,
  output logic          owner,
  output logic          timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CMD   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          rr_pref;     // requester preferred when both are valid
  logic          first_blk;   // next command is init rather than next
  logic          last_blk;    // block in flight closes the job
  logic          abort_q;     // one-cycle timeout abort pulse
  logic [15:0]   cnt;

  logic          gnt;
  logic          sel_valid;
  logic          sel_last;
  logic          sel_rsp_ready;
  logic [383:0]  gnt_key;
  logic [1023:0] sel_block;
  logic          timed_out;

  // Requester selection: grant candidate and owner-indexed input views
  always_comb begin
    gnt           = (req_valid == 2'b11) ? rr_pref : req_valid[1];
    gnt_key       = gnt ? req_key[767:384] : req_key[383:0];
    sel_valid     = owner ? req_valid[1] : req_valid[0];
    sel_last      = owner ? req_last[1]  : req_last[0];
    sel_rsp_ready = owner ? rsp_ready[1] : rsp_ready[0];
    sel_block     = owner ? req_block[2047:1024] : req_block[1023:0];
    timed_out     = ((state == S_ISSUE) || (state == S_WAIT)) && (cnt == CNT_LAST);
  end

  // Handshake and command outputs decoded from the registered state;
  // zeroize suppresses any handshake so nothing is silently consumed
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if ((state == S_ISSUE) && sel_valid && !timed_out && !zeroize) begin
      req_ready = owner ? 2'b10 : 2'b01;
    end
    if ((state == S_RESP) && !zeroize) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
    core_init    = (state == S_CMD) && core_ready && first_blk  && !zeroize;
    core_next    = (state == S_CMD) && core_ready && !first_blk && !zeroize;
    core_zeroize = zeroize | abort_q;
    timeout_err  = abort_q;
    busy         = (state != S_IDLE);
  end

  // Scheduler FSM, data latches and timeout counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      rr_pref    <= 1'b0;
      first_blk  <= 1'b0;
      last_blk   <= 1'b0;
      abort_q    <= 1'b0;
      cnt        <= 16'd0;
      core_key   <= '0;
      core_block <= '0;
      rsp_tag    <= '0;
    end else if (zeroize) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      rr_pref    <= 1'b0;
      first_blk  <= 1'b0;
      last_blk   <= 1'b0;
      abort_q    <= 1'b0;
      cnt        <= 16'd0;
      core_key   <= '0;
      core_block <= '0;
      rsp_tag    <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // no grant while the core is still being wiped after an abort
          if ((|req_valid) && core_ready && !abort_q) begin
            owner     <= gnt;
            core_key  <= gnt_key;
            first_blk <= 1'b1;
            cnt       <= 16'd0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (timed_out) begin
            abort_q    <= 1'b1;
            core_key   <= '0;
            core_block <= '0;
            rsp_tag    <= '0;
            first_blk  <= 1'b0;
            cnt        <= 16'd0;
            rr_pref    <= ~owner;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
            if (sel_valid) begin
              core_block <= sel_block;
              last_blk   <= sel_last;
              state      <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (core_ready) begin
            first_blk <= 1'b0;
            cnt       <= 16'd0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (timed_out) begin
            abort_q    <= 1'b1;
            core_key   <= '0;
            core_block <= '0;
            rsp_tag    <= '0;
            first_blk  <= 1'b0;
            cnt        <= 16'd0;
            rr_pref    <= ~owner;
            state      <= S_IDLE;
          end else if (core_tag_valid) begin
            if (last_blk) begin
              rsp_tag <= core_tag;
              state   <= S_RESP;
            end else begin
              cnt   <= 16'd0;
              state <= S_ISSUE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (sel_rsp_ready) begin
            rsp_tag    <= '0;
            core_key   <= '0;
            core_block <= '0;
            rr_pref    <= ~owner;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hmac_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hmac_sched
//  Description : Directed per-cycle vector table plus hand-written corner
//                sequences for hmac_sched (TIMEOUT_CYCLES = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hmac_sched;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          zeroize = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_last = 2'b00;
  logic [1:0]    req_ready;
  logic [767:0]  req_key;
  logic [2047:0] req_block;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b00;
  logic [383:0]  rsp_tag;
  logic          core_init, core_next, core_zeroize;
  logic          core_ready = 1'b0;
  logic          core_tag_valid = 1'b0;
  logic [383:0]  core_key;
  logic [1023:0] core_block;
  logic [383:0]  core_tag;
  logic          busy, owner, timeout_err;

  localparam logic [383:0]  KEY0 = {12{32'h1111_0a0a}};
  localparam logic [383:0]  KEY1 = {12{32'h2222_0b0b}};
  localparam logic [1023:0] BLK0 = {32{32'h3333_0c0c}};
  localparam logic [1023:0] BLK1 = {32{32'h4444_0d0d}};
  localparam logic [383:0]  TAG  = {48{8'hA5}};

  hmac_sched #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .req_key(req_key), .req_block(req_block),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .core_init(core_init), .core_next(core_next), .core_zeroize(core_zeroize),
    .core_ready(core_ready), .core_tag_valid(core_tag_valid),
    .core_key(core_key), .core_block(core_block), .core_tag(core_tag),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign req_key   = {KEY1, KEY0};
  assign req_block = {BLK1, BLK0};
  assign core_tag  = TAG;

  int total = 0;
  int bad   = 0;

  // key/blk selector codes: 0 = zero, 1 = requester 0 value, 2 = requester 1 value, 3 = don't care
  typedef struct packed {
    logic rst; logic zz; logic [1:0] rv; logic [1:0] rl; logic cr; logic ctv; logic [1:0] rr;
    logic [1:0] e_rdy; logic e_init; logic e_next; logic [1:0] e_rv; logic e_busy; logic e_own;
    logic e_tag; logic [1:0] e_key; logic [1:0] e_blk; logic e_cz; logic e_te;
  } vec_t;

  vec_t vq[$];

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic chk2(input string n, input logic [1:0] a, input logic [1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic chkw(input string n, input logic [1023:0] a, input logic [1023:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got ..%h want ..%h (t=%0t)", n, a[63:0], e[63:0], $time);
    end
  endtask

  function automatic logic [1023:0] keyval(input logic [1:0] s);
    case (s)
      2'd1:    return {640'd0, KEY0};
      2'd2:    return {640'd0, KEY1};
      default: return '0;
    endcase
  endfunction

  function automatic logic [1023:0] blkval(input logic [1:0] s);
    case (s)
      2'd1:    return BLK0;
      2'd2:    return BLK1;
      default: return '0;
    endcase
  endfunction

  // drive one cycle of inputs at the falling edge, settle before sampling
  task automatic cyc(input int rst, input int zz, input int rv, input int rl,
                     input int cr, input int ctv, input int rr);
    @(negedge clk);
    reset_n        = (rst == 0);
    zeroize        = 1'(zz);
    req_valid      = 2'(rv);
    req_last       = 2'(rl);
    core_ready     = 1'(cr);
    core_tag_valid = 1'(ctv);
    rsp_ready      = 2'(rr);
    #1;
  endtask

  task automatic add(input int rst, input int zz, input int rv, input int rl, input int cr,
                     input int ctv, input int rr, input int rdy, input int ini, input int nxt,
                     input int rvl, input int bsy, input int own, input int tag, input int key,
                     input int blk, input int cz, input int te);
    vec_t v;
    v.rst = 1'(rst); v.zz = 1'(zz); v.rv = 2'(rv); v.rl = 2'(rl); v.cr = 1'(cr);
    v.ctv = 1'(ctv); v.rr = 2'(rr); v.e_rdy = 2'(rdy); v.e_init = 1'(ini);
    v.e_next = 1'(nxt); v.e_rv = 2'(rvl); v.e_busy = 1'(bsy); v.e_own = 1'(own);
    v.e_tag = 1'(tag); v.e_key = 2'(key); v.e_blk = 2'(blk); v.e_cz = 1'(cz); v.e_te = 1'(te);
    vq.push_back(v);
  endtask

  vec_t v;
  int   pulses;

  initial begin
    //   rst zz rv rl cr tv rr | rdy ini nxt rvl bsy own tag key blk cz te
    // reset state
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single job on requester 0, one block, last=1
    add(0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0,   1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
    // three-block job on requester 1: init, next, next
    add(0, 0, 2, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
    add(0, 0, 2, 0, 1, 0, 0,   2, 0, 0, 0, 1, 1, 0, 2, 3, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 2, 0, 1, 0, 0,   2, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 2, 2, 1, 0, 0,   2, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    // response: wrong-requester ready ignored; req0 waits until IDLE
    add(0, 0, 1, 0, 1, 0, 1,   0, 0, 0, 2, 1, 1, 1, 2, 2, 0, 0);
    add(0, 0, 1, 0, 1, 0, 2,   0, 0, 0, 2, 1, 1, 1, 2, 2, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0, 3, 3, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0,   1, 0, 0, 0, 1, 0, 0, 1, 3, 0, 0);
    // both valid from reset: grants 0, 1, 0
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 3, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 3, 3, 1, 1, 0,   0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 3, 3, 1, 0, 3,   0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   2, 0, 0, 0, 1, 1, 0, 2, 3, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   0, 1, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 3, 3, 1, 1, 0,   0, 0, 0, 0, 1, 1, 0, 2, 2, 0, 0);
    add(0, 0, 3, 3, 1, 0, 3,   0, 0, 0, 2, 1, 1, 1, 2, 2, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0, 3, 3, 0, 0);
    add(0, 0, 3, 3, 1, 0, 0,   1, 0, 0, 0, 1, 0, 0, 1, 3, 0, 0);
    // CMD stall, then zeroize in WAIT followed by ready/tag_valid
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      v = vq[i];
      cyc(v.rst, v.zz, v.rv, v.rl, v.cr, v.ctv, v.rr);
      chk2($sformatf("v%0d req_ready", i), req_ready, v.e_rdy);
      chk1($sformatf("v%0d core_init", i), core_init, v.e_init);
      chk1($sformatf("v%0d core_next", i), core_next, v.e_next);
      chk2($sformatf("v%0d rsp_valid", i), rsp_valid, v.e_rv);
      chk1($sformatf("v%0d busy", i), busy, v.e_busy);
      chk1($sformatf("v%0d owner", i), owner, v.e_own);
      chk1($sformatf("v%0d core_zeroize", i), core_zeroize, v.e_cz);
      chk1($sformatf("v%0d timeout_err", i), timeout_err, v.e_te);
      chkw($sformatf("v%0d rsp_tag", i), {640'd0, rsp_tag}, v.e_tag ? {640'd0, TAG} : '0);
      if (v.e_key != 2'd3) chkw($sformatf("v%0d core_key", i), {640'd0, core_key}, keyval(v.e_key));
      if (v.e_blk != 2'd3) chkw($sformatf("v%0d core_block", i), core_block, blkval(v.e_blk));
    end

    // core_ready low for 20 cycles in CMD: no pulse until it rises, then exactly one
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      pulses += int'(core_init) + int'(core_next);
      chk1($sformatf("stall%0d busy", k), busy, 1'b1);
    end
    chk1("stall no_pulse", (pulses == 0), 1'b1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk1("stall release init", core_init, 1'b1);
    pulses += int'(core_init) + int'(core_next);
    cyc(0, 0, 0, 0, 1, 0, 0);
    pulses += int'(core_init) + int'(core_next);
    cyc(0, 0, 0, 0, 1, 1, 0);
    pulses += int'(core_init) + int'(core_next);
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk2("stall rsp_valid", rsp_valid, 2'b01);
    chk1("stall one_pulse", (pulses == 1), 1'b1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk1("stall idle", busy, 1'b0);

    // timeout in WAIT: pulse 8 cycles after WAIT entry, no response
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk1($sformatf("wto%0d timeout_err", k), timeout_err, 1'b0);
      chk1($sformatf("wto%0d busy", k), busy, 1'b1);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk1("wto timeout_err", timeout_err, 1'b1);
    chk1("wto core_zeroize", core_zeroize, 1'b1);
    chk1("wto busy", busy, 1'b0);
    chk2("wto rsp_valid", rsp_valid, 2'b00);
    chkw("wto core_key", {640'd0, core_key}, '0);
    chkw("wto core_block", core_block, '0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk1("wto pulse_end", timeout_err, 1'b0);
    chk1("wto zeroize_end", core_zeroize, 1'b0);
    chk2("wto no_rsp", rsp_valid, 2'b00);

    // pointer advanced after abort: both valid -> requester 1; then ISSUE timeout
    cyc(0, 0, 3, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk1("ito owner", owner, 1'b1);
    for (int k = 1; k < 8; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk1($sformatf("ito%0d timeout_err", k), timeout_err, 1'b0);
      chk1($sformatf("ito%0d busy", k), busy, 1'b1);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk1("ito timeout_err", timeout_err, 1'b1);
    chk1("ito busy", busy, 1'b0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 3, 0, 1, 0, 0);
    cyc(0, 0, 3, 0, 1, 0, 0);
    chk1("ito next owner", owner, 1'b0);
    chk2("ito next ready", req_ready, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
